// File: rtl/load_store_unit.sv
// load_store_unit: bridges pipeline load/store requests onto a simple
// request/acknowledge data bus, one transaction at a time.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_size            00 word, 01 half, 10 byte, 11 illegal
//   req_signed          sign-extend load result
//   req_addr/req_wdata  byte address, right-aligned store data
//   resp_valid          one-cycle response pulse
//   resp_err            misaligned, illegal size or bus timeout
//   resp_rdata          extended load data (0 for stores and errors)
//   DAD/MREQ/WRITE/SIZE bus address, request, direction, size
//   ddt_o/ddt_oe/ddt_i  bus write data, its driver enable, read data
//   ACKD_n              bus acknowledge, active-low
module load_store_unit #(
    parameter int TIMEOUT   = 255,
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    output logic [BIT_WIDTH-1:0] ddt_o,
    output logic                 ddt_oe,
    input  logic [BIT_WIDTH-1:0] ddt_i,
    input  logic                 ACKD_n
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // Last counter value that still waits; the next unacked edge aborts.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic                 sgn_q;
    logic                 fault;
    logic [BIT_WIDTH-1:0] wdata_al;
    logic [BIT_WIDTH-1:0] rdata_ext;

    always_comb begin
        fault = 1'b0;
        case (req_size)
            2'b00:   fault = (req_addr[1:0] != 2'b00);
            2'b01:   fault = req_addr[0];
            2'b11:   fault = 1'b1;
            default: fault = 1'b0;
        endcase
    end

    always_comb begin
        wdata_al = req_wdata;
        case (req_size)
            2'b01:   wdata_al = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
            2'b10:   wdata_al = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
            default: wdata_al = req_wdata;
        endcase
    end

    // Extension uses the latched size/sign, since the request fields
    // may change once the request has been accepted.
    always_comb begin
        rdata_ext = ddt_i;
        case (SIZE)
            2'b01:   rdata_ext = {{(BIT_WIDTH-16){sgn_q & ddt_i[15]}},
                                  ddt_i[15:0]};
            2'b10:   rdata_ext = {{(BIT_WIDTH-8){sgn_q & ddt_i[7]}},
                                  ddt_i[7:0]};
            default: rdata_ext = ddt_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            DAD        <= '0;
            ddt_o      <= '0;
            ddt_oe     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            cnt        <= 8'd0;
            sgn_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (fault) begin
                            // No bus cycle for a faulty request.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state  <= BUS;
                            MREQ   <= 1'b1;
                            DAD    <= req_addr;
                            WRITE  <= req_write;
                            SIZE   <= req_size;
                            sgn_q  <= req_signed;
                            cnt    <= 8'd0;
                            ddt_oe <= req_write;
                            ddt_o  <= req_write ? wdata_al : '0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // Acknowledge wins over a timeout on the same edge.
                    if (!ACKD_n) begin
                        state      <= RESP;
                        MREQ       <= 1'b0;
                        ddt_oe     <= 1'b0;
                        ddt_o      <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= WRITE ? '0 : rdata_ext;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        MREQ       <= 1'b0;
                        ddt_oe     <= 1'b0;
                        ddt_o      <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios for load_store_unit.
// DUT built with TIMEOUT=4 so the timeout path is short.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] ddt_o;
    logic        ddt_oe;
    logic [31:0] ddt_i;
    logic        ACKD_n;

    int checks;
    int failures;

    load_store_unit #(
        .TIMEOUT  (4),
        .BIT_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .DAD       (DAD),
        .MREQ      (MREQ),
        .WRITE     (WRITE),
        .SIZE      (SIZE),
        .ddt_o     (ddt_o),
        .ddt_oe    (ddt_oe),
        .ddt_i     (ddt_i),
        .ACKD_n    (ACKD_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready act=%b exp=0", req_ready);
        end
        checks++;
        if ({MREQ, WRITE, SIZE, ddt_oe} !== 5'b0) begin
            failures++;
            $display("FAIL rst_bus act=%b exp=0",
                     {MREQ, WRITE, SIZE, ddt_oe});
        end
        checks++;
        if ({DAD, ddt_o, resp_rdata} !== 96'b0) begin
            failures++;
            $display("FAIL rst_data act=%h %h %h exp=0",
                     DAD, ddt_o, resp_rdata);
        end
        checks++;
        if ({resp_valid, resp_err} !== 2'b00) begin
            failures++;
            $display("FAIL rst_resp act=%b exp=00",
                     {resp_valid, resp_err});
        end
        rst = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_after act=%b exp=1", req_ready);
        end
    endtask

    task automatic test_load_byte();
        issue(1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0);
        ddt_i = 32'h0000_0080;
        step();
        req_valid = 1'b0;
        checks++;
        if ({MREQ, WRITE, SIZE, req_ready} !== 5'b1_0_10_0) begin
            failures++;
            $display("FAIL lb_bus act=%b exp=10100",
                     {MREQ, WRITE, SIZE, req_ready});
        end
        checks++;
        if (DAD !== 32'h0800_0003) begin
            failures++;
            $display("FAIL lb_dad act=%h exp=08000003", DAD);
        end
        checks++;
        if (resp_valid !== 1'b0 || ddt_oe !== 1'b0) begin
            failures++;
            $display("FAIL lb_early act=%b%b exp=00",
                     resp_valid, ddt_oe);
        end
        ACKD_n = 1'b0;
        step();
        ACKD_n = 1'b1;
        checks++;
        if ({resp_valid, resp_err, MREQ} !== 3'b100) begin
            failures++;
            $display("FAIL lb_resp act=%b exp=100",
                     {resp_valid, resp_err, MREQ});
        end
        checks++;
        if (resp_rdata !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_rdata act=%h exp=ffffff80", resp_rdata);
        end
        step();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL lb_done act=%b exp=01",
                     {resp_valid, req_ready});
        end
    endtask

    task automatic test_store_half();
        issue(1'b1, 2'b01, 1'b0, 32'h0800_0002, 32'h1234_ABCD);
        ACKD_n = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({MREQ, WRITE, ddt_oe, resp_valid} !== 4'b1110) begin
                failures++;
                $display("FAIL sh_bus%0d act=%b exp=1110", i,
                         {MREQ, WRITE, ddt_oe, resp_valid});
            end
            checks++;
            if (ddt_o !== 32'h0000_ABCD || SIZE !== 2'b01) begin
                failures++;
                $display("FAIL sh_ddt%0d act=%h/%b exp=0000abcd/01",
                         i, ddt_o, SIZE);
            end
            if (i == 3) ACKD_n = 1'b0;
            step();
        end
        ACKD_n = 1'b1;
        checks++;
        if ({resp_valid, resp_err, MREQ, ddt_oe} !== 4'b1000) begin
            failures++;
            $display("FAIL sh_resp act=%b exp=1000",
                     {resp_valid, resp_err, MREQ, ddt_oe});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL sh_rdata act=%h exp=0", resp_rdata);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL sh_once act=%b exp=0", resp_valid);
        end
    endtask

    task automatic test_misaligned();
        ACKD_n = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 32'h0800_0001, 32'h0);
        step();
        req_valid = 1'b0;
        checks++;
        if ({MREQ, resp_valid, resp_err} !== 3'b011) begin
            failures++;
            $display("FAIL mis_resp act=%b exp=011",
                     {MREQ, resp_valid, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mis_rdata act=%h exp=0", resp_rdata);
        end
        step();
        checks++;
        if ({MREQ, resp_valid, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL mis_done act=%b exp=001",
                     {MREQ, resp_valid, req_ready});
        end
        issue(1'b0, 2'b11, 1'b0, 32'h0800_0000, 32'h0);
        step();
        req_valid = 1'b0;
        checks++;
        if ({MREQ, resp_valid, resp_err} !== 3'b011) begin
            failures++;
            $display("FAIL ill_resp act=%b exp=011",
                     {MREQ, resp_valid, resp_err});
        end
        step();
        ACKD_n = 1'b1;
    endtask

    task automatic test_timeout();
        ACKD_n = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 32'h0800_0004, 32'h0);
        ddt_i = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({MREQ, resp_valid} !== 2'b10) begin
                failures++;
                $display("FAIL to_wait%0d act=%b exp=10", i,
                         {MREQ, resp_valid});
            end
            step();
        end
        checks++;
        if ({MREQ, resp_valid, resp_err} !== 3'b011) begin
            failures++;
            $display("FAIL to_resp act=%b exp=011",
                     {MREQ, resp_valid, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL to_rdata act=%h exp=0", resp_rdata);
        end
        step();
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL to_ready act=%b exp=10",
                     {req_ready, resp_valid});
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b01, 1'b0, 32'h0800_0010, 32'h0);
        step();
        issue(1'b0, 2'b01, 1'b0, 32'h0800_0012, 32'h0);
        ddt_i  = 32'h0000_8001;
        ACKD_n = 1'b0;
        step();
        ACKD_n = 1'b1;
        checks++;
        if ({resp_valid, resp_err} !== 2'b10 ||
            resp_rdata !== 32'h0000_8001) begin
            failures++;
            $display("FAIL b2b_first act=%b/%h exp=10/00008001",
                     {resp_valid, resp_err}, resp_rdata);
        end
        step();
        checks++;
        if ({req_ready, resp_valid, MREQ} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_gap act=%b exp=100",
                     {req_ready, resp_valid, MREQ});
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (MREQ !== 1'b1 || DAD !== 32'h0800_0012) begin
            failures++;
            $display("FAIL b2b_second act=%b/%h exp=1/08000012",
                     MREQ, DAD);
        end
        ddt_i  = 32'h0000_7FFF;
        ACKD_n = 1'b0;
        step();
        ACKD_n = 1'b1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_7FFF) begin
            failures++;
            $display("FAIL b2b_second_rdata act=%b/%h exp=1/00007fff",
                     resp_valid, resp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_bus();
        int seen;
        ACKD_n = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'h0800_0020, 32'h5555_AAAA);
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({MREQ, ddt_oe, resp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL rmb_drop act=%b exp=000",
                     {MREQ, ddt_oe, resp_valid});
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rmb_noresp act=%0d exp=0", seen);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h0800_0024, 32'h0);
        step();
        req_valid = 1'b0;
        ddt_i  = 32'hDEAD_BEEF;
        ACKD_n = 1'b0;
        step();
        ACKD_n = 1'b1;
        checks++;
        if ({resp_valid, resp_err} !== 2'b10 ||
            resp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rmb_next act=%b/%h exp=10/deadbeef",
                     {resp_valid, resp_err}, resp_rdata);
        end
        step();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        ddt_i      = 32'h0;
        ACKD_n     = 1'b1;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
